// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
//   Shared types for the command-driven interval timer: controller states
//   and command opcodes as they appear on cmd_op.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_START  = 2'd0,
        OP_STOP   = 2'd1,
        OP_PAUSE  = 2'd2,
        OP_RESUME = 2'd3
    } op_e;

endpackage

// File: rtl/counter_ctrl_tick_prescaler.sv
// tick_prescaler
//   PRESCALE_W-bit divider producing one tick every prescale+1 enabled cycles.
//   Ports:
//     clk       clock, posedge
//     rst       synchronous active-low reset
//     en        advance the divider this cycle (frozen when low)
//     clr       zero the divider (has priority over en)
//     prescale  terminal value of the divider
//     tick      combinational: divider at terminal value and en high
module tick_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] div;

    assign tick = en && (div == prescale);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div <= '0;
        end else if (clr) begin
            div <= '0;
        end else if (en) begin
            if (div == prescale) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Programmable interval timer sequencer. Accepts START/STOP/PAUSE/RESUME
//   commands, prescales the clock, counts ticks up to a terminal count and
//   signals each expiry with a one-cycle pulse and a sticky irq.
//   Ports:
//     clk, rst       clock (posedge) and synchronous active-low reset
//     cmd_valid/ready command handshake (cmd_ready registered)
//     cmd_op         0=START 1=STOP 2=PAUSE 3=RESUME
//     cmd_periodic   START only: periodic (1) or one-shot (0)
//     cmd_limit      START only: terminal count
//     cmd_prescale   START only: one tick every prescale+1 cycles
//     irq_clr        clears irq (an expiry on the same edge wins)
//     count, busy, expire, irq  registered status outputs
//
//   state  | meaning
//   IDLE   | reset / stopped, count held at 0
//   RUN    | prescaler and count advancing
//   PAUSED | count and prescaler frozen
//   DONE   | one-shot expired, count held at limit
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic                  cmd_periodic,
    input  logic [WIDTH-1:0]      cmd_limit,
    input  logic [PRESCALE_W-1:0] cmd_prescale,
    input  logic                  irq_clr,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  expire,
    output logic                  irq
);

    state_e                state;
    logic [WIDTH-1:0]      lim_q;
    logic [PRESCALE_W-1:0] psc_q;
    logic                  per_q;
    op_e                   op;
    logic                  accept;
    logic                  psc_clr;
    logic                  psc_en;
    logic                  tick;

    assign op      = op_e'(cmd_op);
    assign accept  = cmd_valid && cmd_ready;
    assign psc_clr = accept && (op == OP_START || op == OP_STOP);
    // Any accepted command owns the edge: the prescaler does not step, so a
    // coinciding tick is discarded and a PAUSE freezes on exactly this edge.
    assign psc_en  = (state == RUN) && !accept;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (psc_en),
        .clr      (psc_clr),
        .prescale (psc_q),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            lim_q     <= '0;
            psc_q     <= '0;
            per_q     <= 1'b0;
            expire    <= 1'b0;
            irq       <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            cmd_ready <= 1'b1;
            expire    <= 1'b0;
            if (irq_clr) begin
                irq <= 1'b0;
            end

            if (accept) begin
                case (op)
                    OP_START: begin
                        count <= '0;
                        lim_q <= cmd_limit;
                        psc_q <= cmd_prescale;
                        per_q <= cmd_periodic;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                    OP_STOP: begin
                        count <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    OP_PAUSE: begin
                        if (state == RUN) begin
                            state <= PAUSED;
                        end
                    end
                    OP_RESUME: begin
                        if (state == PAUSED) begin
                            state <= RUN;
                        end
                    end
                    default: ;
                endcase
            end else if (tick) begin
                if (count == lim_q) begin
                    expire <= 1'b1;
                    irq    <= 1'b1;
                    if (per_q) begin
                        count <= '0;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_periodic;
    logic [7:0] cmd_limit;
    logic [3:0] cmd_prescale;
    logic       irq_clr;
    logic [7:0] count;
    logic       busy;
    logic       expire;
    logic       irq;

    int errors = 0;
    int checks = 0;

    counter_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_periodic (cmd_periodic),
        .cmd_limit    (cmd_limit),
        .cmd_prescale (cmd_prescale),
        .irq_clr      (irq_clr),
        .count        (count),
        .busy         (busy),
        .expire       (expire),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a timer is "elapsed prescaler steps since START".
    // Expiry happens whenever the step count reaches (L+1)(P+1); the count
    // is simply how many whole prescale periods have elapsed.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
    int m_mode = M_IDLE, m_steps = 0, m_L = 0, m_P = 0, m_per = 0;
    int m_irq = 0, m_exp = 0, m_rdy = 0;

    function automatic int m_count();
        int period;
        period = (m_L + 1) * (m_P + 1);
        if (m_mode == M_IDLE) return 0;
        if (m_mode == M_DONE) return m_L;
        return (m_steps % period) / (m_P + 1);
    endfunction

    task automatic model_edge();
        int period;
        if (!rst) begin
            m_mode = M_IDLE; m_steps = 0; m_L = 0; m_P = 0; m_per = 0;
            m_irq = 0; m_exp = 0; m_rdy = 0;
        end else begin
            m_exp = 0;
            if (irq_clr) m_irq = 0;
            if (cmd_valid && m_rdy != 0) begin
                case (int'(cmd_op))
                    0: begin
                        m_steps = 0; m_L = int'(cmd_limit); m_P = int'(cmd_prescale);
                        m_per = int'(cmd_periodic); m_mode = M_RUN;
                    end
                    1: begin m_steps = 0; m_mode = M_IDLE; end
                    2: if (m_mode == M_RUN) m_mode = M_PAUSED;
                    default: if (m_mode == M_PAUSED) m_mode = M_RUN;
                endcase
            end else if (m_mode == M_RUN) begin
                period = (m_L + 1) * (m_P + 1);
                m_steps++;
                if (m_steps == period) begin
                    m_exp = 1; m_irq = 1;
                    if (m_per != 0) m_steps = 0;
                    else m_mode = M_DONE;
                end
            end
            m_rdy = 1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] op, input logic per,
                         input logic [7:0] lim, input logic [3:0] psc, input logic clr);
        rst = r; cmd_valid = v; cmd_op = op; cmd_periodic = per;
        cmd_limit = lim; cmd_prescale = psc; irq_clr = clr;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 4'd0, 1'b0);
    endtask

    // One clock: model consumes the held inputs, then outputs are sampled
    // at the following negedge.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       r, v;
        logic [1:0] op;
        logic       per;
        logic [7:0] lim;
        logic [3:0] psc;
        logic       clr;
        int         e_cnt, e_busy, e_exp, e_irq, e_rdy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] op,
                                input logic [7:0] lim, input logic clr,
                                input int c, input int b, input int e, input int i, input int rd);
        vec_t t;
        t.r = r; t.v = v; t.op = op; t.per = 1'b0; t.lim = lim; t.psc = 4'd0; t.clr = clr;
        t.e_cnt = c; t.e_busy = b; t.e_exp = e; t.e_irq = i; t.e_rdy = rd;
        return t;
    endfunction

    vec_t tbl[14];

    initial begin
        int exp_edge;
        idle();
        // Reset with a START offered, then one-shot L=3 P=0 and ignored commands.
        tbl[0]  = mk(0, 1, 2'd0, 8'd3, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 2'd0, 8'd3, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 2'd0, 8'd3, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 2'd0, 8'd3, 0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(1, 1, 2'd0, 8'd3, 0, 0, 1, 0, 0, 1);
        tbl[5]  = mk(1, 0, 2'd0, 8'd0, 0, 1, 1, 0, 0, 1);
        tbl[6]  = mk(1, 0, 2'd0, 8'd0, 0, 2, 1, 0, 0, 1);
        tbl[7]  = mk(1, 0, 2'd0, 8'd0, 0, 3, 1, 0, 0, 1);
        tbl[8]  = mk(1, 0, 2'd0, 8'd0, 0, 3, 0, 1, 1, 1);
        tbl[9]  = mk(1, 0, 2'd0, 8'd0, 0, 3, 0, 0, 1, 1);
        tbl[10] = mk(1, 1, 2'd2, 8'd0, 0, 3, 0, 0, 1, 1);
        tbl[11] = mk(1, 0, 2'd0, 8'd0, 1, 3, 0, 0, 0, 1);
        tbl[12] = mk(1, 1, 2'd1, 8'd0, 0, 0, 0, 0, 0, 1);
        tbl[13] = mk(1, 1, 2'd3, 8'd0, 0, 0, 0, 0, 0, 1);

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].op, tbl[i].per, tbl[i].lim, tbl[i].psc, tbl[i].clr);
            step();
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_cnt);
            chk($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].e_busy);
            chk($sformatf("tbl%0d_expire", i), int'(expire), tbl[i].e_exp);
            chk($sformatf("tbl%0d_irq", i), int'(irq), tbl[i].e_irq);
            chk($sformatf("tbl%0d_ready", i), int'(cmd_ready), tbl[i].e_rdy);
        end

        // Periodic L=2 P=1: expire after every 6th edge, count steps every 2.
        drive(1, 1, 2'd0, 1, 8'd2, 4'd1, 0);
        step();
        idle();
        for (int i = 1; i <= 30; i++) begin
            step();
            chk("per_count", int'(count), (i % 6) / 2);
            chk("per_expire", int'(expire), (i % 6 == 0) ? 1 : 0);
        end

        // Pause/resume: L=5 P=0 would expire at edge 6; 7 frozen edges -> 13.
        drive(1, 1, 2'd0, 0, 8'd5, 4'd0, 0);
        step();
        idle(); step(); step();
        chk("pause_pre_count", int'(count), 2);
        drive(1, 1, 2'd2, 0, 8'd0, 4'd0, 0);
        step();
        chk("pause_busy", int'(busy), 1);
        idle();
        for (int i = 4; i <= 8; i++) begin
            step();
            chk("pause_hold", int'(count), 2);
        end
        drive(1, 1, 2'd3, 0, 8'd0, 4'd0, 0);
        step();
        idle();
        exp_edge = -1;
        for (int e = 10; e <= 40; e++) begin
            step();
            if (expire) begin exp_edge = e; break; end
        end
        chk("pause_expiry_edge", exp_edge, 13);

        // STOP on the expiry edge: no expire, irq untouched.
        drive(1, 0, 2'd0, 0, 8'd0, 4'd0, 1);
        step();
        drive(1, 1, 2'd0, 1, 8'd1, 4'd0, 0);
        step();
        idle(); step();
        drive(1, 1, 2'd1, 0, 8'd0, 4'd0, 0);
        step();
        chk("stop_col_expire", int'(expire), 0);
        chk("stop_col_irq", int'(irq), 0);
        chk("stop_col_busy", int'(busy), 0);
        idle(); step();
        chk("stop_col_after", int'(expire), 0);

        // irq_clr on the expiry edge: set wins.
        drive(1, 1, 2'd0, 1, 8'd1, 4'd0, 0);
        step();
        idle(); step();
        drive(1, 0, 2'd0, 0, 8'd0, 4'd0, 1);
        step();
        chk("clr_col_expire", int'(expire), 1);
        chk("clr_col_irq", int'(irq), 1);

        // START while running restarts at 0.
        idle(); step();
        chk("restart_pre", int'(count), 1);
        drive(1, 1, 2'd0, 0, 8'd7, 4'd0, 0);
        step();
        chk("restart_count", int'(count), 0);
        chk("restart_busy", int'(busy), 1);
        idle(); step();
        chk("restart_next", int'(count), 1);

        // Reset mid-run at count 4 of L=9.
        drive(1, 1, 2'd0, 0, 8'd9, 4'd0, 0);
        step();
        idle();
        for (int i = 0; i < 4; i++) step();
        chk("rmid_pre_count", int'(count), 4);
        chk("rmid_pre_irq", int'(irq), 1);
        drive(0, 0, 2'd0, 0, 8'd0, 4'd0, 0);
        step();
        chk("rmid_count", int'(count), 0);
        chk("rmid_busy", int'(busy), 0);
        chk("rmid_expire", int'(expire), 0);
        chk("rmid_irq", int'(irq), 0);
        chk("rmid_ready", int'(cmd_ready), 0);
        idle(); step();
        chk("rmid_ready_rise", int'(cmd_ready), 1);

        // Full range L=255 one-shot.
        drive(1, 1, 2'd0, 0, 8'd255, 4'd0, 0);
        step();
        idle();
        for (int i = 1; i <= 255; i++) begin
            step();
            chk("full_count", int'(count), i);
            if (expire) chk("full_early_expire", 1, 0);
        end
        step();
        chk("full_expire", int'(expire), 1);
        chk("full_hold", int'(count), 255);
        chk("full_done_busy", int'(busy), 0);

        // Random commands against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] lim;
            lim = ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
            drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 11) == 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), lim,
                  (lim == 8'd255) ? 4'd0 : 4'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0));
            step();
            chk("rnd_count", int'(count), m_count());
            chk("rnd_busy", int'(busy), (m_mode == M_RUN || m_mode == M_PAUSED) ? 1 : 0);
            chk("rnd_expire", int'(expire), m_exp);
            chk("rnd_irq", int'(irq), m_irq);
            chk("rnd_ready", int'(cmd_ready), m_rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
